uart_tx_arbiter: RTL

- Shares one UART_Tx peripheral transmit path among three byte-stream requesters, e.g. three processor-side message sources multiplexed onto one serial line.
- Round-robin arbitration runs at message granularity: a requester keeps the grant until its byte flagged "last" is accepted.
- Each byte is issued to the UART as a one-cycle write strobe, and the arbiter waits for the UART busy flag to clear before issuing the next byte.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular sharing of one UART transmit path among three requesters
// Define UART_TX_ARB_TIMEOUT_EN to add a grant timeout and the o_timeout port.
module uart_tx_arbiter #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_TIMEOUT    = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [G_DATA_WIDTH-1:0] i_req1_data,
  input  logic [G_DATA_WIDTH-1:0] i_req2_data,
  input  logic [G_DATA_WIDTH-1:0] i_req3_data,
  input  logic                    i_req1_valid,
  input  logic                    i_req2_valid,
  input  logic                    i_req3_valid,
  input  logic                    i_req1_last,
  input  logic                    i_req2_last,
  input  logic                    i_req3_last,
  output logic                    o_req1_ready,
  output logic                    o_req2_ready,
  output logic                    o_req3_ready,
  output logic [2:0]              o_grant,
  output logic [G_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_wr,
  input  logic                    i_tx_busy,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic                    o_timeout,
`endif
  output logic                    o_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE, DRAIN} state_t;

  state_t                  state;
  logic [1:0]              ptr;       // index of the requester granted most recently
  logic                    lock_end;
  logic [2:0]              valid_vec;
  logic [1:0]              cand1;
  logic [1:0]              cand2;
  logic [1:0]              pick_idx;
  logic                    pick_any;
  logic [2:0]              pick;
  logic                    own_valid;
  logic                    own_last;
  logic [G_DATA_WIDTH-1:0] own_data;
  logic                    accept;

  // A timeout shorter than two cycles cannot be expressed by the counter.
  if (G_TIMEOUT < 2) begin : g_timeout_too_small
  end

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign valid_vec = {i_req3_valid, i_req2_valid, i_req1_valid};
  assign cand1     = next_idx(ptr);
  assign cand2     = next_idx(cand1);

  always_comb begin
    pick_any = 1'b1;
    pick_idx = ptr;
    if (valid_vec[cand1])      pick_idx = cand1;
    else if (valid_vec[cand2]) pick_idx = cand2;
    else if (valid_vec[ptr])   pick_idx = ptr;
    else                       pick_any = 1'b0;
  end

  assign pick = 3'b001 << pick_idx;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    if (o_grant[0]) begin
      own_valid = i_req1_valid;
      own_last  = i_req1_last;
      own_data  = i_req1_data;
    end else if (o_grant[1]) begin
      own_valid = i_req2_valid;
      own_last  = i_req2_last;
      own_data  = i_req2_data;
    end else if (o_grant[2]) begin
      own_valid = i_req3_valid;
      own_last  = i_req3_last;
      own_data  = i_req3_data;
    end
  end

  assign o_req1_ready = (state == GRANT) && o_grant[0] && !i_tx_busy;
  assign o_req2_ready = (state == GRANT) && o_grant[1] && !i_tx_busy;
  assign o_req3_ready = (state == GRANT) && o_grant[2] && !i_tx_busy;
  assign accept       = (state == GRANT) && own_valid && !i_tx_busy;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(G_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(G_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      ptr       <= 2'd2;
      o_grant   <= '0;
      o_tx_data <= '0;
      o_tx_wr   <= 1'b0;
      o_busy    <= 1'b0;
      lock_end  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_tx_wr <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            o_grant <= pick;
            ptr     <= pick_idx;
            state   <= GRANT;
            o_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (accept) begin
            o_tx_data <= own_data;
            o_tx_wr   <= 1'b1;
            lock_end  <= own_last;
            state     <= SETTLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (!own_valid) begin
            // ptr already names the stalled owner, so it goes to the back of the order
            if (tmo_cnt == TMO_MAX) begin
              o_timeout <= 1'b1;
              o_grant   <= '0;
              state     <= IDLE;
              o_busy    <= 1'b0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`endif
        end
        SETTLE: begin
          // busy is not trusted yet: the UART gets this cycle to raise it
          state <= DRAIN;
        end
        DRAIN: begin
          if (!i_tx_busy) begin
            if (lock_end) begin
              o_grant <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              state <= GRANT;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
